// File: rtl/fetch_unit.sv
// Instruction fetch unit: in-order prefetch into a small FIFO, with redirect flush and stale-response drop.
// Optional FETCH_MISALIGN_CHECK_EN adds misalign_o and halts fetch on a misaligned redirect target.
module fetch_unit #(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [31:0]   r_redir_pc;
    logic          r_redir_pend;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_stale;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [31:0]   r_mem_data [FIFO_DEPTH];
    logic [31:0]   r_mem_pc   [FIFO_DEPTH];

    logic          w_pop;
    logic          w_push;
    logic          w_grant;
    logic          w_hold;
    logic          w_blk;
    logic          w_stale_dec;
    logic [CW:0]   w_sum;
    logic [CW-1:0] w_out_nx;
    logic [CW-1:0] w_stale_nx;
    logic [31:0]   w_redir_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;
    assign misalign_o = r_misalign;
    // A held (already presented) request must still complete before fetch halts.
    assign w_blk      = r_misalign & ~r_redir_pend;
    assign w_redir_pc = redirect_pc_i;
`else
    assign w_blk      = 1'b0;
    assign w_redir_pc = redirect_pc_i & ~32'h3;
`endif

    // A same-cycle pop frees a slot, so the stream stays back-to-back with a shallow FIFO.
    assign w_pop       = (r_count != '0) & instr_ready_i;
    assign w_sum       = (CW+1)'(r_out) + (CW+1)'(r_count) - (CW+1)'(w_pop);
    assign imem_req_o  = (r_state != IDLE) & (w_sum < (CW+1)'(FIFO_DEPTH)) & ~w_blk;
    assign imem_addr_o = r_pc;
    assign w_grant     = imem_req_o & imem_gnt_i;
    assign w_hold      = redirect_i & imem_req_o & ~imem_gnt_i;

    // On redirect everything still in flight, including a grant this cycle, becomes stale.
    assign w_out_nx    = r_out + CW'(w_grant) - CW'(imem_rvalid_i);
    assign w_stale_dec = imem_rvalid_i & (r_stale != '0);
    assign w_stale_nx  = redirect_i ? w_out_nx
                       : r_stale - CW'(w_stale_dec) + CW'(w_grant & r_redir_pend);
    assign w_push      = imem_rvalid_i & (r_stale == '0) & ~redirect_i;

    assign instr_valid_o = (r_count != '0);
    assign instr_o       = instr_valid_o ? r_mem_data[r_rd] : 32'h0;
    assign instr_pc_o    = instr_valid_o ? r_mem_pc[r_rd]   : 32'h0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_rsp_pc     <= RESET_PC;
            r_redir_pc   <= RESET_PC;
            r_redir_pend <= 1'b0;
            r_out        <= '0;
            r_stale      <= '0;
        end else begin
            case (r_state)
                IDLE:    r_state <= FETCH;
                FETCH:   if (w_stale_nx != '0) r_state <= FLUSH;
                FLUSH:   if (w_stale_nx == '0) r_state <= FETCH;
                default: r_state <= IDLE;
            endcase
            r_out        <= w_out_nx;
            r_stale      <= w_stale_nx;
            r_redir_pend <= redirect_i ? w_hold : (r_redir_pend & ~w_grant);
            if (redirect_i) begin
                r_redir_pc <= w_redir_pc;
                if (!w_hold) r_pc <= w_redir_pc;
            end else if (w_grant) begin
                r_pc <= r_redir_pend ? r_redir_pc : r_pc + 32'd4;
            end
            // PC of the next non-stale response; those follow sequentially from the redirect target.
            if (redirect_i)  r_rsp_pc <= w_redir_pc;
            else if (w_push) r_rsp_pc <= r_rsp_pc + 32'd4;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= 32'h0;
                r_mem_pc[i]   <= 32'h0;
            end
        end else if (redirect_i) begin
            r_count <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr] <= imem_rdata_i;
                r_mem_pc[r_wr]   <= r_rsp_pc;
                r_wr             <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)           r_misalign <= 1'b0;
        else if (redirect_i) r_misalign <= |redirect_pc_i[1:0];
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle tables for streaming/backpressure/grant stall,
// plus hand sequences for redirect flush, held-request redirect, PC wrap and alignment.
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i    = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i  = 32'h0;
    logic        redirect_i    = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    fetch_unit #(.FIFO_DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i)
`ifdef FETCH_MISALIGN_CHECK_EN
        , .misalign_o(misalign_o)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction word the memory returns for a given address.
    function automatic logic [31:0] D(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset;
        #2 reset = 1'b1;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        redirect_i = 0; redirect_pc_i = 0; instr_ready_i = 0;
        #1;
        chk("rst req",   {31'h0, imem_req_o},    32'h0);
        chk("rst addr",  imem_addr_o,            32'h0);
        chk("rst valid", {31'h0, instr_valid_o}, 32'h0);
        chk("rst instr", instr_o,                32'h0);
        chk("rst ipc",   instr_pc_o,             32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst misalign", {31'h0, misalign_o}, 32'h0);
`endif
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // One cycle: drive inputs after the falling edge, then check outputs (rdata = D(rpc) when rv).
    task automatic step(input string tag, input logic g, input logic rv, input logic [31:0] rpc,
                        input logic rdy, input logic rdr, input logic [31:0] dpc,
                        input logic e_req, input logic [31:0] e_addr,
                        input logic e_val, input logic [31:0] e_ipc);
        @(negedge clock);
        imem_gnt_i    = g;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? D(rpc) : 32'h0;
        instr_ready_i = rdy;
        redirect_i    = rdr;
        redirect_pc_i = dpc;
        #1;
        chk({tag, " req"}, {31'h0, imem_req_o}, {31'h0, e_req});
        if (e_req) chk({tag, " addr"}, imem_addr_o, e_addr);
        chk({tag, " valid"}, {31'h0, instr_valid_o}, {31'h0, e_val});
        if (e_val) begin
            chk({tag, " ipc"},   instr_pc_o, e_ipc);
            chk({tag, " instr"}, instr_o,    D(e_ipc));
        end
    endtask

    typedef struct {
        logic        rst;
        logic        g;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t tv[$];

    task automatic addv(input logic rst, input logic g, input logic rv, input logic [31:0] rpc,
                        input logic rdy, input logic e_req, input logic [31:0] e_addr,
                        input logic e_val, input logic [31:0] e_ipc);
        vec_t v;
        v = '{rst, g, rv, rpc, rdy, e_req, e_addr, e_val, e_ipc};
        tv.push_back(v);
    endtask

    initial begin
        // stream 0,4,8.. back to back, then ready low fills the FIFO and stops requests
        addv(1, 1, 0, 0,     1, 0, 0,     0, 0);
        addv(0, 1, 0, 0,     1, 1, 0,     0, 0);
        addv(0, 1, 1, 0,     1, 1, 4,     0, 0);
        addv(0, 1, 1, 4,     1, 1, 8,     1, 0);
        addv(0, 1, 1, 8,     1, 1, 12,    1, 4);
        addv(0, 1, 1, 12,    1, 1, 16,    1, 8);
        addv(0, 1, 1, 16,    0, 0, 0,     1, 12);
        addv(0, 1, 0, 0,     0, 0, 0,     1, 12);
        addv(0, 1, 0, 0,     0, 0, 0,     1, 12);
        addv(0, 1, 0, 0,     1, 1, 20,    1, 12);
        addv(0, 1, 1, 20,    1, 1, 24,    1, 16);
        addv(0, 0, 1, 24,    1, 1, 28,    1, 20);
        addv(0, 0, 0, 0,     1, 1, 28,    1, 24);
        addv(0, 0, 0, 0,     1, 1, 28,    0, 0);
        // grant withheld for three cycles: address parked at 0x8
        addv(1, 1, 0, 0,     1, 0, 0,     0, 0);
        addv(0, 1, 0, 0,     1, 1, 0,     0, 0);
        addv(0, 1, 1, 0,     1, 1, 4,     0, 0);
        addv(0, 0, 1, 4,     1, 1, 8,     1, 0);
        addv(0, 0, 0, 0,     1, 1, 8,     1, 4);
        addv(0, 0, 0, 0,     1, 1, 8,     0, 0);
        addv(0, 1, 0, 0,     1, 1, 8,     0, 0);
        addv(0, 1, 1, 8,     1, 1, 12,    0, 0);
        addv(0, 0, 0, 0,     1, 1, 16,    1, 8);

        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rst && i != 0) do_reset();
            step($sformatf("tv%0d", i), tv[i].g, tv[i].rv, tv[i].rpc, tv[i].rdy, 1'b0, 32'h0,
                 tv[i].e_req, tv[i].e_addr, tv[i].e_val, tv[i].e_ipc);
        end

        // redirect to 0x100 with two requests in flight: both responses dropped
        do_reset();
        step("rd0", 1, 0, 0,     1, 0, 0,      0, 0,      0, 0);
        step("rd1", 1, 0, 0,     1, 0, 0,      1, 0,      0, 0);
        step("rd2", 1, 0, 0,     1, 0, 0,      1, 4,      0, 0);
        step("rd3", 0, 0, 0,     1, 1, 'h100,  0, 0,      0, 0);
        step("rd4", 1, 1, 0,     1, 0, 0,      0, 0,      0, 0);
        step("rd5", 1, 1, 4,     1, 0, 0,      1, 'h100,  0, 0);
        step("rd6", 1, 1, 'h100, 1, 0, 0,      1, 'h104,  0, 0);
        step("rd7", 1, 1, 'h104, 1, 0, 0,      1, 'h108,  1, 'h100);
        step("rd8", 0, 0, 0,     1, 0, 0,      1, 'h10c,  1, 'h104);

        // redirect while request is presented but not granted: it completes as stale first
        do_reset();
        step("hp0", 0, 0, 0,     1, 0, 0,      0, 0,      0, 0);
        step("hp1", 0, 0, 0,     1, 1, 'h40,   1, 0,      0, 0);
        step("hp2", 1, 0, 0,     1, 0, 0,      1, 0,      0, 0);
        step("hp3", 1, 1, 0,     1, 0, 0,      1, 'h40,   0, 0);
        step("hp4", 0, 1, 'h40,  1, 0, 0,      1, 'h44,   0, 0);
        step("hp5", 0, 0, 0,     1, 0, 0,      1, 'h44,   1, 'h40);

        // fetch PC wraps from the top of the address space
        do_reset();
        step("wr0", 0, 0, 0,     1, 1, 32'hFFFF_FFFC, 0, 0,             0, 0);
        step("wr1", 1, 0, 0,     1, 0, 0,             1, 32'hFFFF_FFFC, 0, 0);
        step("wr2", 0, 0, 0,     1, 0, 0,             1, 32'h0000_0000, 0, 0);

`ifdef FETCH_MISALIGN_CHECK_EN
        do_reset();
        step("ma0", 1, 0, 0,     1, 1, 'h102,  0, 0,      0, 0);
        step("ma1", 1, 0, 0,     1, 0, 0,      0, 0,      0, 0);
        chk("ma1 misalign", {31'h0, misalign_o}, 32'h1);
        step("ma2", 1, 0, 0,     1, 0, 0,      0, 0,      0, 0);
        step("ma3", 1, 0, 0,     1, 1, 'h200,  0, 0,      0, 0);
        chk("ma3 misalign", {31'h0, misalign_o}, 32'h1);
        step("ma4", 1, 0, 0,     1, 0, 0,      1, 'h200,  0, 0);
        chk("ma4 misalign", {31'h0, misalign_o}, 32'h0);
`else
        // low address bits of the redirect target are ignored
        do_reset();
        step("al0", 0, 0, 0,     1, 1, 'h103,  0, 0,      0, 0);
        step("al1", 0, 0, 0,     1, 0, 0,      1, 'h100,  0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
